// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: run-mode encoding and direction constants.
package prog_counter_pkg;

   typedef enum logic [1:0] {
      MODE_FREE    = 2'd0,
      MODE_MODULO  = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_HOLD    = 2'd3
   } cnt_mode_t;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

endpackage

// File: rtl/prog_counter_n_next_calc.sv
// Combinational successor of the count for one step, plus whether that step hits the terminal value.
module counter_next_calc
   import prog_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  cnt_mode_t        mode,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] mod_val,
   output logic [WIDTH-1:0] next_count,
   output logic             hit_tc
);

   logic [WIDTH-1:0] inc, dec;

   assign inc = count + 1'b1;
   assign dec = count - 1'b1;

   always_comb begin
      next_count = count;
      hit_tc     = 1'b0;
      unique case (mode)
         MODE_FREE: begin
            if (up_dn == CNT_UP) begin
               next_count = inc;
               hit_tc     = (count == {WIDTH{1'b1}});
            end else begin
               next_count = dec;
               hit_tc     = (count == '0);
            end
         end
         MODE_MODULO: begin
            if (up_dn == CNT_UP) begin
               if (count >= mod_val) begin
                  next_count = '0;
                  hit_tc     = 1'b1;
               end else begin
                  next_count = inc;
               end
            end else begin
               if (count == '0) begin
                  next_count = mod_val;
                  hit_tc     = 1'b1;
               end else if (count > mod_val) begin
                  // out-of-range count snaps back into the window silently
                  next_count = mod_val;
               end else begin
                  next_count = dec;
               end
            end
         end
         MODE_ONESHOT: begin
            if (up_dn == CNT_UP) begin
               if (count >= mod_val) begin
                  hit_tc = 1'b1;
               end else begin
                  next_count = inc;
                  hit_tc     = (inc == mod_val);
               end
            end else begin
               if (count == '0) begin
                  hit_tc = 1'b1;
               end else begin
                  next_count = dec;
                  hit_tc     = (dec == '0);
               end
            end
         end
         MODE_HOLD: begin
            next_count = count;
            hit_tc     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/prog_counter_n.sv
// Parametrised up/down counter with free/modulo/one-shot modes, load and gated data bus.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module prog_counter_n
   import prog_counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load_e,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] mod_val,
   input  logic             out_e,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_oe,
   output logic             tc,
   output logic             done
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("prog_counter_n: WIDTH out of range");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("prog_counter_n: PRESCALE must be >= 1");
   end

   logic [WIDTH-1:0] count_q, count_d, calc_next;
   logic             tc_q, tc_d, done_q, done_d;
   logic             calc_hit, qual, step;
   cnt_mode_t        mode_s;

   assign mode_s = cnt_mode_t'(mode);

   counter_next_calc #(.WIDTH(WIDTH)) u_calc (
      .count      (count_q),
      .mode       (mode_s),
      .up_dn      (up_dn),
      .mod_val    (mod_val),
      .next_count (calc_next),
      .hit_tc     (calc_hit)
   );

   // a finished one-shot stops consuming en cycles until reloaded
   assign qual = en && !load_e && (mode_s != MODE_HOLD) &&
                 !((mode_s == MODE_ONESHOT) && done_q);

`ifdef COUNTER_PRESCALE_EN
   localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

   logic [PW-1:0] psc_q, psc_d;

   always_comb begin
      psc_d = psc_q;
      if (load_e)    psc_d = '0;
      else if (qual) psc_d = (psc_q == PLAST) ? '0 : psc_q + 1'b1;
   end

   assign step = qual && (psc_q == PLAST);

   always_ff @(posedge clk) begin
      if (!rst_n) psc_q <= '0;
      else        psc_q <= psc_d;
   end
`else
   assign step = qual;
`endif

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (load_e) begin
         count_d = load_val;
         done_d  = 1'b0;
      end else if (step) begin
         count_d = calc_next;
         tc_d    = calc_hit;
         if (mode_s == MODE_ONESHOT && calc_hit) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign done     = done_q;
   assign out_data = out_e ? count_q : '0;
   assign out_oe   = {WIDTH{out_e}};

endmodule

// File: tb/tb_prog_counter_n.sv
// Directed plan steps followed by randomized traffic, all checked against an integer reference model.
module tb_prog_counter_n;

   localparam int W  = 8;
   localparam int PS = 4;
   localparam int MX = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n, en, load_e, up_dn, out_e;
   logic [W-1:0] load_val, mod_val;
   logic [1:0]   mode;
   logic [W-1:0] count, out_data, out_oe;
   logic         tc, done;

   int n_assert = 0;
   int n_fail   = 0;

   int m_cnt, m_psc;
   bit m_tc, m_done;

   always #5 clk = ~clk;

   prog_counter_n #(.WIDTH(W), .PRESCALE(PS)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load_e(load_e), .load_val(load_val),
      .up_dn(up_dn), .mode(mode), .mod_val(mod_val), .out_e(out_e),
      .count(count), .out_data(out_data), .out_oe(out_oe), .tc(tc), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: what one rising edge does, stated directly in terms of count values.
   task automatic model_edge();
      bit qual, stp, up;
      int mv, tgt;
      up = (up_dn == 1'b1);
      mv = int'(mod_val);
      if (!rst_n) begin
         m_cnt = 0; m_tc = 0; m_done = 0; m_psc = 0;
      end else if (load_e) begin
         m_cnt = int'(load_val); m_tc = 0; m_done = 0; m_psc = 0;
      end else begin
         m_tc = 0;
         qual = en && (mode != 2'd3) && !(mode == 2'd2 && m_done);
         stp  = qual;
`ifdef COUNTER_PRESCALE_EN
         if (qual) begin
            if (m_psc == PS - 1) m_psc = 0;
            else begin m_psc++; stp = 0; end
         end
`endif
         if (stp) begin
            case (mode)
               2'd0: begin
                  m_tc  = up ? (m_cnt == MX - 1) : (m_cnt == 0);
                  m_cnt = up ? (m_cnt + 1) % MX : (m_cnt + MX - 1) % MX;
               end
               2'd1: begin
                  if (up) begin
                     if (m_cnt >= mv) begin m_cnt = 0; m_tc = 1; end
                     else m_cnt++;
                  end else begin
                     if (m_cnt == 0) begin m_cnt = mv; m_tc = 1; end
                     else if (m_cnt > mv) m_cnt = mv;
                     else m_cnt--;
                  end
               end
               2'd2: begin
                  tgt = up ? mv : 0;
                  if (up ? (m_cnt >= mv) : (m_cnt == 0)) begin
                     m_tc = 1; m_done = 1;
                  end else begin
                     m_cnt = up ? m_cnt + 1 : m_cnt - 1;
                     if (m_cnt == tgt) begin m_tc = 1; m_done = 1; end
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("count", 32'(count), 32'(m_cnt));
      chk("tc", 32'(tc), 32'(m_tc));
      chk("done", 32'(done), 32'(m_done));
      chk("out_data", 32'(out_data), out_e ? 32'(m_cnt) : 32'd0);
      chk("out_oe", 32'(out_oe), out_e ? 32'(MX - 1) : 32'd0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 0; en = 0; load_e = 0; load_val = '0; up_dn = 1; mode = 2'd0;
      mod_val = '0; out_e = 0;
      m_cnt = 0; m_psc = 0; m_tc = 0; m_done = 0;
      steps(2);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_tc", 32'(tc), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst_n = 1;

      // 1: free-run up across the wrap, bus gated then enabled
      load_e = 1; load_val = 8'hFD; step(); load_e = 0;
      en = 1; steps(3);
      out_e = 1; steps(4);
      out_e = 0;

      // 2: modulo 5 up, then down from 2, then load above the window
      mode = 2'd1; mod_val = 8'd5;
      load_e = 1; load_val = 8'd0; step(); load_e = 0;
      steps(8);
      up_dn = 0; load_e = 1; load_val = 8'd2; step(); load_e = 0;
      steps(4);
      load_e = 1; load_val = 8'd9; step(); load_e = 0;
      steps(3);

      // 3: one-shot down, freeze, reload resumes
      mode = 2'd2;
      load_e = 1; load_val = 8'd3; step(); load_e = 0;
      steps(16);
      chk("oneshot_frozen_count", 32'(count), 32'd0);
      load_e = 1; load_val = 8'd7; step(); load_e = 0;
      chk("oneshot_reload_done", 32'(done), 32'd0);
      steps(3);

      // 4: load beats en; reset beats load
      mode = 2'd0; up_dn = 1;
      load_e = 1; load_val = 8'd10; step(); load_e = 0;
      steps(2);
      load_e = 1; load_val = 8'd42; step(); load_e = 0;
      chk("load_over_en", 32'(count), 32'd42);
      steps(2);
      rst_n = 0; load_e = 1; load_val = 8'd99; step();
      chk("rst_over_load", 32'(count), 32'd0);
      rst_n = 1; load_e = 0;

      // 5: hold, then free down through zero
      load_e = 1; load_val = 8'd0; step(); load_e = 0;
      mode = 2'd3; steps(5);
      mode = 2'd0; up_dn = 0; steps(3);

      // 6: en gaps and reload mid-period (matters only with the prescaler)
      up_dn = 1; steps(2); en = 0; steps(3); en = 1; steps(3);
      load_e = 1; load_val = 8'd20; step(); load_e = 0;
      steps(6);

      // randomized traffic
      mod_val = 8'd6;
      for (int i = 0; i < 600; i++) begin
         rst_n  = ($urandom_range(0, 79) != 0);
         load_e = ($urandom_range(0, 11) == 0);
         en     = ($urandom_range(0, 4) != 0);
         out_e  = $urandom_range(0, 1);
         if ($urandom_range(0, 15) == 0) mode  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)  up_dn = $urandom_range(0, 1);
         if ($urandom_range(0, 19) == 0)
            mod_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
